// File: rtl/vector_processor.sv
// SIMD vector unit: four 16x32-bit vector registers and a private 512-word memory.
// Each clock executes one LOAD/STORE/ADD/MUL instruction; all registers are observable.
module vector_processor (
  input  logic         clk,
  input  logic         reset,
  input  logic [12:0]  instruction,
  output logic [511:0] A1,
  output logic [511:0] A2,
  output logic [511:0] A3,
  output logic [511:0] A4
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_ADD   = 2'b10,
    OP_MUL   = 2'b11
  } opcode_e;

  opcode_e    op;
  logic [1:0] sel;
  logic [8:0] addr;

  assign op   = opcode_e'(instruction[12:11]);
  assign sel  = instruction[10:9];
  assign addr = instruction[8:0];

  logic [511:0] a1_q, a2_q, a3_q, a4_q;
  logic [511:0] a1_d, a2_d, a3_d, a4_d;
  logic [31:0]  mem_q [512];

  logic [511:0] load_vec, store_vec;
  logic [511:0] add_lo, add_hi, mul_lo, mul_hi;
  logic [63:0]  sum, prod;

  // Lane datapath; the 9-bit address sum wraps modulo 512 by construction.
  always_comb begin
    load_vec = '0;
    add_lo   = '0;
    add_hi   = '0;
    mul_lo   = '0;
    mul_hi   = '0;
    sum      = '0;
    prod     = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      load_vec[32*i +: 32] = mem_q[addr + 9'(i)];
      sum  = {32'd0, a1_q[32*i +: 32]} + {32'd0, a2_q[32*i +: 32]};
      prod = 64'(a1_q[32*i +: 32]) * 64'(a2_q[32*i +: 32]);
      add_lo[32*i +: 32] = sum[31:0];
      add_hi[32*i +: 32] = sum[63:32];
      mul_lo[32*i +: 32] = prod[31:0];
      mul_hi[32*i +: 32] = prod[63:32];
    end
  end

  always_comb begin
    store_vec = a1_q;
    case (sel)
      2'b00:   store_vec = a1_q;
      2'b01:   store_vec = a2_q;
      2'b10:   store_vec = a3_q;
      default: store_vec = a4_q;
    endcase
  end

  always_comb begin
    a1_d = a1_q;
    a2_d = a2_q;
    a3_d = a3_q;
    a4_d = a4_q;
    case (op)
      OP_LOAD: begin
        case (sel)
          2'b00:   a1_d = load_vec;
          2'b01:   a2_d = load_vec;
          2'b10:   a3_d = load_vec;
          default: a4_d = load_vec;
        endcase
      end
      OP_ADD: begin
        a3_d = add_lo;
        a4_d = add_hi;
      end
      OP_MUL: begin
        a3_d = mul_lo;
        a4_d = mul_hi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1_q <= '0;
      a2_q <= '0;
      a3_q <= '0;
      a4_q <= '0;
    end else begin
      a1_q <= a1_d;
      a2_q <= a2_d;
      a3_q <= a3_d;
      a4_q <= a4_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < 512; k++) begin
        mem_q[k] <= 32'(k);
      end
    end else if (op == OP_STORE) begin
      for (int unsigned i = 0; i < 16; i++) begin
        mem_q[addr + 9'(i)] <= store_vec[32*i +: 32];
      end
    end
  end

  assign A1 = a1_q;
  assign A2 = a2_q;
  assign A3 = a3_q;
  assign A4 = a4_q;

endmodule

// File: tb/tb_vector_processor.sv
// Directed self-checking bench for vector_processor: load/store/add/mul,
// address wrap, high-half and carry results, and asynchronous reset.
module tb_vector_processor;

  logic         clk;
  logic         reset;
  logic [12:0]  instruction;
  logic [511:0] A1, A2, A3, A4;

  int tests_run;
  int tests_failed;

  vector_processor dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .A1         (A1),
    .A2         (A2),
    .A3         (A3),
    .A4         (A4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] ins(input logic [1:0] op, input logic [1:0] sel,
                                      input int unsigned a);
    return {op, sel, 9'(a)};
  endfunction

  // Vector whose lane i is (base + step*i) mod 2^32.
  function automatic logic [511:0] ramp(input int unsigned base, input int unsigned step);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = 32'(base + step * 32'(i));
    return v;
  endfunction

  task automatic exec(input logic [12:0] i);
    @(negedge clk);
    instruction = i;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    instruction = ins(2'b10, 2'b00, 0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [511:0] zero;
    zero = '0;
    do_reset();
    tests_run++;
    if ({A1, A2, A3, A4} !== {zero, zero, zero, zero}) begin
      tests_failed++;
      $display("FAIL reset_regs got A1=%h A4=%h exp 0", A1, A4);
    end
    exec(ins(2'b10, 2'b00, 0));
    tests_run++;
    if ({A3, A4} !== {zero, zero}) begin
      tests_failed++;
      $display("FAIL add_zero got A3=%h A4=%h exp 0", A3, A4);
    end
    exec(ins(2'b11, 2'b00, 0));
    tests_run++;
    if ({A3, A4} !== {zero, zero}) begin
      tests_failed++;
      $display("FAIL mul_zero got A3=%h A4=%h exp 0", A3, A4);
    end
  endtask

  task automatic test_load_add();
    exec(ins(2'b00, 2'b00, 1));
    exec(ins(2'b00, 2'b01, 8));
    tests_run++;
    if (A1 !== ramp(1, 1)) begin
      tests_failed++;
      $display("FAIL load_a1 got %h exp %h", A1, ramp(1, 1));
    end
    tests_run++;
    if (A2 !== ramp(8, 1)) begin
      tests_failed++;
      $display("FAIL load_a2 got %h exp %h", A2, ramp(8, 1));
    end
    exec(ins(2'b10, 2'b11, 300));
    tests_run++;
    if (A3 !== ramp(9, 2) || A3[511:480] !== 32'h27) begin
      tests_failed++;
      $display("FAIL add_a3 got %h exp %h", A3, ramp(9, 2));
    end
    tests_run++;
    if (A4 !== 512'd0) begin
      tests_failed++;
      $display("FAIL add_a4 got %h exp 0", A4);
    end
  endtask

  task automatic test_store();
    logic [511:0] exp;
    exec(ins(2'b01, 2'b10, 1));
    exec(ins(2'b00, 2'b00, 1));
    tests_run++;
    if (A1 !== ramp(9, 2)) begin
      tests_failed++;
      $display("FAIL store_a3_reload got %h exp %h", A1, ramp(9, 2));
    end
    exec(ins(2'b01, 2'b11, 8));
    exec(ins(2'b00, 2'b00, 1));
    // The A4 store (all zero) overwrote mem[8..16], i.e. lanes 7..15 here.
    exp = ramp(9, 2);
    exp[511:224] = '0;
    tests_run++;
    if (A1 !== exp) begin
      tests_failed++;
      $display("FAIL store_overlap got %h exp %h", A1, exp);
    end
    exec(ins(2'b00, 2'b01, 8));
    tests_run++;
    if (A2 !== 512'd0) begin
      tests_failed++;
      $display("FAIL store_a4_zero got %h exp 0", A2);
    end
  endtask

  task automatic test_mul();
    logic [511:0] exp;
    do_reset();
    exec(ins(2'b00, 2'b00, 2));
    exec(ins(2'b00, 2'b01, 3));
    exec(ins(2'b11, 2'b00, 0));
    exp = '0;
    for (int i = 0; i < 16; i++) exp[32*i +: 32] = 32'((2 + i) * (3 + i));
    tests_run++;
    if (A3 !== exp || A3[31:0] !== 32'd6 || A3[511:480] !== 32'h132) begin
      tests_failed++;
      $display("FAIL mul_a3 got %h exp %h", A3, exp);
    end
    tests_run++;
    if (A4 !== 512'd0) begin
      tests_failed++;
      $display("FAIL mul_a4 got %h exp 0", A4);
    end
    exec(ins(2'b01, 2'b10, 2));
    exec(ins(2'b00, 2'b00, 2));
    tests_run++;
    if (A1 !== exp) begin
      tests_failed++;
      $display("FAIL mul_store_reload got %h exp %h", A1, exp);
    end
  endtask

  task automatic test_wrap();
    logic [511:0] exp;
    do_reset();
    exec(ins(2'b00, 2'b00, 510));
    exp = '0;
    exp[31:0]   = 32'd510;
    exp[63:32]  = 32'd511;
    for (int i = 2; i < 16; i++) exp[32*i +: 32] = 32'(i - 2);
    tests_run++;
    if (A1 !== exp || A1[511:480] !== 32'd13) begin
      tests_failed++;
      $display("FAIL wrap_load got %h exp %h", A1, exp);
    end
  endtask

  // Repeated squaring of lane i = i: the fourth MUL yields i^16, overflowing 32 bits.
  task automatic test_mul_high();
    logic [31:0]  val [16];
    logic [511:0] elo, ehi;
    longint unsigned p;
    do_reset();
    exec(ins(2'b00, 2'b00, 0));
    exec(ins(2'b00, 2'b01, 0));
    for (int i = 0; i < 16; i++) val[i] = 32'(i);
    for (int r = 0; r < 4; r++) begin
      exec(ins(2'b11, 2'b00, 0));
      elo = '0;
      ehi = '0;
      for (int i = 0; i < 16; i++) begin
        p = longint'(val[i]) * longint'(val[i]);
        elo[32*i +: 32] = p[31:0];
        ehi[32*i +: 32] = p[63:32];
        val[i] = p[31:0];
      end
      tests_run++;
      if (A3 !== elo || A4 !== ehi) begin
        tests_failed++;
        $display("FAIL mul_square_round%0d got A3=%h A4=%h exp A3=%h A4=%h", r, A3, A4, elo, ehi);
      end
      exec(ins(2'b01, 2'b10, 100));
      exec(ins(2'b00, 2'b00, 100));
      exec(ins(2'b00, 2'b01, 100));
    end
    tests_run++;
    if (A4[511:480] !== 32'h5B27AC99) begin
      tests_failed++;
      $display("FAIL mul_high_lane15 got %h exp 5b27ac99", A4[511:480]);
    end
  endtask

  // Builds 0xFFFFFFFF in lane 0 as 65535*65537, then adds 1 to it.
  task automatic test_add_carry();
    do_reset();
    exec(ins(2'b00, 2'b00, 256));
    exec(ins(2'b00, 2'b01, 256));
    exec(ins(2'b11, 2'b00, 0));
    exec(ins(2'b01, 2'b10, 300));
    exec(ins(2'b00, 2'b00, 300));
    exec(ins(2'b00, 2'b01, 1));
    exec(ins(2'b10, 2'b00, 0));
    exec(ins(2'b01, 2'b10, 320));
    exec(ins(2'b00, 2'b00, 255));
    exec(ins(2'b00, 2'b01, 257));
    exec(ins(2'b11, 2'b00, 0));
    exec(ins(2'b01, 2'b10, 340));
    exec(ins(2'b00, 2'b00, 340));
    exec(ins(2'b00, 2'b01, 320));
    exec(ins(2'b11, 2'b00, 0));
    tests_run++;
    if (A3[31:0] !== 32'hFFFFFFFF || A4[31:0] !== 32'd0) begin
      tests_failed++;
      $display("FAIL build_all_ones got A3=%h A4=%h exp ffffffff/0", A3[31:0], A4[31:0]);
    end
    exec(ins(2'b01, 2'b10, 360));
    exec(ins(2'b00, 2'b00, 360));
    exec(ins(2'b00, 2'b01, 1));
    exec(ins(2'b10, 2'b00, 0));
    tests_run++;
    if (A3[31:0] !== 32'd0 || A4[31:0] !== 32'd1) begin
      tests_failed++;
      $display("FAIL add_carry got A3=%h A4=%h exp 0/1", A3[31:0], A4[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    exec(ins(2'b00, 2'b00, 40));
    exec(ins(2'b00, 2'b01, 41));
    exec(ins(2'b10, 2'b00, 0));
    exec(ins(2'b01, 2'b10, 1));
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({A1, A2, A3, A4} !== 2048'd0) begin
      tests_failed++;
      $display("FAIL reset_async got A1=%h A3=%h exp 0", A1, A3);
    end
    instruction = ins(2'b00, 2'b00, 5);
    @(posedge clk);
    #1;
    tests_run++;
    if (A1 !== 512'd0) begin
      tests_failed++;
      $display("FAIL reset_dominates got %h exp 0", A1);
    end
    @(negedge clk);
    instruction = ins(2'b10, 2'b00, 0);
    reset = 1'b0;
    exec(ins(2'b00, 2'b00, 1));
    tests_run++;
    if (A1[31:0] !== 32'd1 || A1 !== ramp(1, 1)) begin
      tests_failed++;
      $display("FAIL reset_mem_init got %h exp %h", A1, ramp(1, 1));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    instruction  = 13'd0;
    test_reset();
    test_load_add();
    test_store();
    test_mul();
    test_wrap();
    test_mul_high();
    test_add_carry();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vector_processor.md
# vector_processor

Register-based SIMD vector unit with four 512-bit vector registers (A1–A4) and a private 512 × 32-bit data memory. It executes one 13-bit instruction per clock: vector load, vector store, lane-wise add, or lane-wise multiply. All four registers are exposed as outputs for observation by the surrounding system and benches.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears registers and initializes memory.
- instruction  input  13  [12:11] opcode, [10:9] register select, [8:0] memory word address.
- A1  output  512  vector register 1 (registered).
- A2  output  512  vector register 2 (registered).
- A3  output  512  vector register 3; low half of add/mul results.
- A4  output  512  vector register 4; high half of add/mul results.

## Operation
- Vector layout: 16 lanes × 32 bits; lane i = bits [32i+31:32i], lane 0 at the LSBs.
- Register select [10:9]: 00=A1, 01=A2, 10=A3, 11=A4.
- Opcode 00, LOAD: selected register lane i <= mem[(addr+i) mod 512], i=0..15.
- Opcode 01, STORE: mem[(addr+i) mod 512] <= selected register lane i.
- Opcode 10, ADD: per lane, unsigned 64-bit result = A1.lane + A2.lane (zero-extended).
  - A3.lane <= result[31:0].
  - A4.lane <= result[63:32], which is the carry: 0 or 1.
  - Register select and address are ignored.
- Opcode 11, MUL: per lane, unsigned 64-bit product = A1.lane × A2.lane.
  - A3.lane <= product[31:0].
  - A4.lane <= product[63:32].
  - Register select and address are ignored.
- ADD and MUL read A1 and A2 before the edge and write A3 and A4 only.
- Memory: 512 words × 32 bits, internal, not externally visible.
- Address wrap: all address arithmetic is modulo 512.
- No valid/enable signal: the instruction present at every rising edge executes.
  - Holding LOAD or STORE is idempotent.
  - Holding ADD or MUL recomputes from the current A1/A2.

## Timing
- Reset asserted (asynchronous, immediate):
  - A1–A4 = 0.
  - mem[k] = k (zero-extended) for k = 0..511.
- Reset dominates instruction; no instruction executes while reset is high.
- Reset asserted mid-sequence discards all prior state.
- Latency: 1 cycle. Results appear on A1–A4 right after the rising edge that samples the instruction.
- STORE writes memory at that edge. A LOAD on the next edge sees the stored data.
- No same-cycle memory forwarding is needed, since only one instruction executes per edge.
- The instruction must be stable around the rising edge.

## Test plan
- Reset, then ADD -> A3 = A4 = 0. Then MUL -> A3 = A4 = 0.
- LOAD A1 from addr 1 (0000000000001) and LOAD A2 from addr 8 (0001000001000) ->
  - A1 lane i = 1+i; lane 0 = 0x1, lane 15 = 0x10.
  - A2 lane i = 8+i.
  - ADD then gives A3 lane i = 9+2i (lane 15 = 0x27), A4 = 0.
- After that ADD: STORE A3 to addr 1 (0110000000001), STORE A4 to addr 8 (0111000001000), then LOAD A1 from addr 1 ->
  - A1 lane i = 9+2i.
  - mem[8..23] = 0.
- LOAD A1 from addr 2, LOAD A2 from addr 3, MUL ->
  - A3 lane i = (2+i)(3+i): lane 0 = 6, lane 15 = 306 (0x132).
  - A4 = 0.
  - STORE A3 to addr 2 (0110000000010), then LOAD to verify.
- LOAD A1 from addr 510 -> lane 0 = 510, lane 1 = 511, lane 2 = 0, lane 15 = 13 (wrap-around).
- Carry/high half: repeat MUL of A3 into A1 and A2 via STORE/LOAD until a lane exceeds 2^32.
  - Check that the A4 lane equals product[63:32].
  - Check ADD carry with 0xFFFFFFFF + 1 -> A3 lane = 0, A4 lane = 1.
- Assert reset mid-sequence -> A1–A4 clear immediately, without waiting for a clock edge; mem[1] reads back 1.
